// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, fed LSB-first.
// Optional two's-complement overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, a_sr_next;
  logic [WIDTH-1:0] b_sr, b_sr_next;
  logic [WIDTH-1:0] res_sr, res_sr_next;
  logic             carry, carry_next;
  logic [CW-1:0]    count, count_next;
  logic             busy_next, done_next, c_out_next;
  logic [WIDTH-1:0] sum_next, res_shifted;
  logic             cell_p, cell_s, cell_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_next;
`endif

  // Single gate-level full-adder cell
  assign cell_p  = a_sr[0] ^ b_sr[0];
  assign cell_s  = cell_p ^ carry;
  assign cell_co = (a_sr[0] & b_sr[0]) | (cell_p & carry);

  // New sum bit enters at the MSB end; works for WIDTH=1 too
  assign res_shifted = WIDTH'({cell_s, res_sr} >> 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    a_sr_next   = a_sr;
    b_sr_next   = b_sr;
    res_sr_next = res_sr;
    carry_next  = carry;
    count_next  = count;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    sum_next    = sum;
    c_out_next  = c_out;
`ifdef SERIAL_ADD_OVF_EN
    ovf_next    = ovf;
`endif
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next  = RUN;
          a_sr_next   = a;
          b_sr_next   = b;
          res_sr_next = '0;
          carry_next  = c_in;
          count_next  = '0;
          busy_next   = 1'b1;
        end
      end
      RUN: begin
        a_sr_next   = a_sr >> 1;
        b_sr_next   = b_sr >> 1;
        res_sr_next = res_shifted;
        carry_next  = cell_co;
        count_next  = CW'(count + CW'(1));
        if (count == LAST) begin
          // Result registers load on the last bit so they are valid in the DONE cycle
          state_next = DONE;
          done_next  = 1'b1;
          sum_next   = res_shifted;
          c_out_next = cell_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_next   = carry ^ cell_co;
`endif
        end else begin
          busy_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      a_sr   <= a_sr_next;
      b_sr   <= b_sr_next;
      res_sr <= res_sr_next;
      carry  <= carry_next;
      count  <= count_next;
      busy   <= busy_next;
      done   <= done_next;
      sum    <= sum_next;
      c_out  <= c_out_next;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= ovf_next;
`endif
    end
  end

endmodule
